flop_fifo: RTL and testbench
============================

# flop_fifo

Synchronous first-in/first-out buffer built entirely from flip-flops, storing `depth` words of `bits` width. It sits between a producer and a consumer on a single clock domain. It presents the oldest stored word on `Dout` at all times (first-word-fall-through) and flags `full` and pending data (`pndng`). The block is the DUT of the FIFO verification environment, which drives it through the `fifo_if` interface.

## Interface
- `depth` — default 8 — number of storage entries; any integer ≥ 2.
- `bits` — default 16 — data word width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `Din`  input  `bits`  write data, sampled on `clk` when `push`=1.
- `push`  input  1  write request.
- `pop`  input  1  read request; removes the word currently on `Dout`.
- `Dout`  output  `bits`  oldest stored word; 0 when empty.
- `full`  output  1  asserted when count == `depth`.
- `pndng`  output  1  asserted when count ≥ 1 (data pending).

## Operation
- Circular buffer: `depth` registers, write pointer, read pointer, occupancy count (width clog2(`depth`)+1). Pointers wrap from `depth`-1 to 0.
- Push, not full: store `Din` at the write pointer, advance the write pointer, count +1.
- Push while full with no pop: the write is ignored. Contents, pointers and count are unchanged.
- Pop, not empty: advance the read pointer, count −1.
- Pop while empty: ignored, no state change.
- Push and pop in the same cycle, not empty: both performed, count unchanged. This holds when full as well; the new word is accepted.
- Push and pop in the same cycle, empty: only the push takes effect, and count becomes 1.
- `Dout` is driven combinationally from the register at the read pointer when `pndng`=1, and is 0 otherwise.
- `full` and `pndng` are decoded combinationally from the registered count.

## Timing
- Reset (`rst`=0 at a rising edge) overrides push and pop. It sets pointers and count to 0 and clears all storage to 0.
- Outputs after reset: `Dout`=0, `full`=0, `pndng`=0.
- Reset asserted mid-operation discards all stored data at that edge.
- Write latency: a word pushed at edge N is visible on `Dout` after edge N if the FIFO was empty, and `pndng` rises after edge N.
- Pop: the next word (or 0) appears on `Dout` after the popping edge.
- `full` rises after the edge that stores the `depth`-th word and falls after the first pop without a simultaneous push.
- No handshake beyond the level signals. Push and pop are single-cycle strobes, sampled every rising edge.

## Structure
- No shared package is required. If the environment's package defines data-width and depth constants, the defaults match them (16, 8).
- Single module; no sub-modules needed. The pointer/count logic may optionally be factored into `fifo_ptr_ctrl`.
- Storage is a register array, not an inferred RAM.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, then release → `Dout`=0, `full`=0, `pndng`=0.
- Fill and drain, `depth`=8: push 0x0001…0x0008 → `full`=1 after the 8th edge. Pop 8 times → `Dout` reads 0x0001…0x0008 in order, then `pndng`=0 and `Dout`=0.
- Overflow: with the FIFO full, push 0xDEAD → ignored. Subsequent pops return 0x0001…0x0008, and 0xDEAD never appears.
- Underflow: pop on an empty FIFO for 3 cycles → state unchanged. A following push of 0x1234 → `Dout`=0x1234, `pndng`=1.
- Simultaneous push and pop:
  - Holding 3 words, push 0xAAAA and pop together → count stays 3, and the head advances.
  - When full, push and pop together → `full` stays 1, and 0xAAAA is accepted at the tail.
  - When empty, push and pop together → 1 word stored.
- Wrap-around and mid-reset: perform 20 random push/pop cycles that cross the pointer wrap, checking against a reference queue. Then assert `rst` with 5 words stored → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/flop_fifo_pkg.sv
// Shared constants and types for the flip-flop FIFO.
package flop_fifo_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_BITS  = 16;

  // Operations actually performed at the next edge, after full/empty qualification.
  typedef struct packed {
    logic wr;
    logic rd;
  } fifo_op_t;

  function automatic int ptr_w(input int d);
    return (d > 2) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/flop_fifo_ptr_ctrl.sv
// Read/write pointers and occupancy count for the flip-flop FIFO.
module flop_fifo_ptr_ctrl
  import flop_fifo_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  output fifo_op_t      op_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic          full_o,
  output logic          pndng_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fifo_op_t      op;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full_o  = (cnt_q == CW'(DEPTH));
    pndng_o = (cnt_q != '0);
    // A simultaneous pop frees the slot, so a push while full is still accepted.
    op.wr   = push_i && (!full_o || pop_i);
    op.rd   = pop_i && pndng_o;
    wr_ptr_d = op.wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = op.rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({op.wr, op.rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign op_o     = op;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/flop_fifo.sv
// First-word-fall-through FIFO built from a register array; Dout shows the head word.
module flop_fifo
  import flop_fifo_pkg::*;
#(
  parameter int depth = DEF_DEPTH,
  parameter int bits  = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
);

  localparam int PW = ptr_w(depth);

  fifo_op_t                        op;
  logic [PW-1:0]                   wr_ptr, rd_ptr;
  logic [depth-1:0][bits-1:0]      mem_q;

  flop_fifo_ptr_ctrl #(.DEPTH(depth)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .op_o     (op),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .full_o   (full),
    .pndng_o  (pndng)
  );

  // One register per entry, each loaded only when the write pointer selects it.
  for (genvar i = 0; i < depth; i++) begin : g_entry
    logic we;
    assign we = op.wr && (wr_ptr == PW'(i));
    always_ff @(posedge clk) begin
      if (!rst)    mem_q[i] <= '0;
      else if (we) mem_q[i] <= Din;
    end
  end

  assign Dout = pndng ? mem_q[rd_ptr] : '0;

endmodule

// File: tb/tb_flop_fifo.sv
// Directed + random bench for flop_fifo with a queue scoreboard.
module tb_flop_fifo;
  localparam int DEPTH = 8;
  localparam int BITS  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            push = 1'b0;
  logic            pop  = 1'b0;
  logic [BITS-1:0] din  = '0;
  logic [BITS-1:0] dout;
  logic            full, pndng;

  always #5 clk = ~clk;

  flop_fifo #(.depth(DEPTH), .bits(BITS)) dut (
    .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop),
    .Dout(dout), .full(full), .pndng(pndng)
  );

  logic [BITS-1:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [BITS-1:0] exp_d;
    exp_d = '0;
    if (sb.size() != 0) exp_d = sb[0];
    chk({tag, ".dout"},  dout,  exp_d);
    chk({tag, ".full"},  full,  sb.size() == DEPTH);
    chk({tag, ".pndng"}, pndng, sb.size() != 0);
  endtask

  // One clock with the given strobes; the scoreboard follows the reference rules.
  task automatic cyc(input logic ps, input logic pp, input logic [BITS-1:0] d, input string tag);
    int  s;
    logic wr, rd;
    s  = sb.size();
    wr = ps && (s < DEPTH || pp);
    rd = pp && (s > 0);
    push = ps; pop = pp; din = d;
    @(posedge clk);
    if (rd) void'(sb.pop_front());
    if (wr) sb.push_back(d);
    #1;
    push = 1'b0; pop = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    // Reset held for two edges
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    chk("rst.dout", dout, 0);
    chk("rst.full", full, 0);
    chk("rst.pndng", pndng, 0);

    // Fill 1..8
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, BITS'(i), "fill");
    chk("fill.full", full, 1);
    chk("fill.head", dout, 16'h0001);

    // Overflow is ignored
    cyc(1'b1, 1'b0, 16'hDEAD, "ovf");
    chk("ovf.head", dout, 16'h0001);

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0, "drain");
      chk("drain.val", dout, (i < DEPTH) ? i + 1 : 0);
    end
    chk("drain.pndng", pndng, 0);

    // Underflow
    repeat (3) cyc(1'b0, 1'b1, '0, "udf");
    cyc(1'b1, 1'b0, 16'h1234, "after_udf");
    chk("after_udf.dout", dout, 16'h1234);
    chk("after_udf.pndng", pndng, 1);

    // Simultaneous push/pop with 3 words
    cyc(1'b1, 1'b0, 16'h0002, "p3");
    cyc(1'b1, 1'b0, 16'h0003, "p3");
    cyc(1'b1, 1'b1, 16'hAAAA, "pp3");
    chk("pp3.head", dout, 16'h0002);
    chk("pp3.cnt", sb.size(), 3);

    // Simultaneous push/pop while full
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, BITS'(16'h0010 + i), "tofull");
    chk("tofull.full", full, 1);
    cyc(1'b1, 1'b1, 16'hAAAA, "ppfull");
    chk("ppfull.full", full, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, '0, "drain2");
    chk("drain2.empty", pndng, 0);

    // Simultaneous push/pop while empty
    cyc(1'b1, 1'b1, 16'h5555, "ppempty");
    chk("ppempty.dout", dout, 16'h5555);
    cyc(1'b0, 1'b1, '0, "ppempty_pop");

    // Random traffic across the pointer wrap
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), BITS'($urandom), "rand");

    // Mid-operation reset with 5 words stored
    while (sb.size() > 5) cyc(1'b0, 1'b1, '0, "trim");
    while (sb.size() < 5) cyc(1'b1, 1'b0, BITS'($urandom), "top");
    rst = 1'b0;
    push = 1'b1; din = 16'hBEEF;
    @(posedge clk);
    #1;
    push = 1'b0;
    rst = 1'b1;
    sb.delete();
    chk("mrst.dout", dout, 0);
    chk("mrst.full", full, 0);
    chk("mrst.pndng", pndng, 0);
    cyc(1'b1, 1'b0, 16'h0077, "post_rst");
    chk("post_rst.dout", dout, 16'h0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
